lbist_controller: RTL
=====================

# lbist_controller

Logic-BIST sequencer for the 36-input / 7-output c432 combinational core under test (CUT). Muxes a 36-bit LFSR pattern generator onto the CUT inputs in place of functional inputs, compacts CUT responses into a 16-bit MISR for a programmed pattern count, and reports the signature with a start/done handshake. Sits between the functional input path and the CUT; the CUT itself is instantiated outside this block.

## Interface
- NUM_PATTERNS, 1000, patterns applied per run (1..65535)
- CNT_W, 16, pattern-counter width
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  level request; sampled in IDLE
- abort  in  1  synchronous abort, any state to IDLE
- seed  in  36  LFSR seed, captured in SEED state
- func_in  in  36  functional CUT inputs
- cut_out  in  7  CUT responses (combinational from cut_in)
- golden  in  16  expected signature (used only with LBIST_GOLDEN_CMP_EN)
- cut_in  out  36  CUT input bus
- bist_mode  out  1  1 while patterns are being driven
- busy  out  1  1 in SEED or APPLY
- done  out  1  1 in DONE
- signature  out  16  MISR contents
- pass  out  1  signature == golden, valid while done
- pattern_cnt  out  CNT_W  patterns applied this run

## Operation
- FSM states: IDLE, SEED, APPLY, DONE.
- IDLE: start=1 -> SEED.
- SEED (1 cycle): lfsr <= seed, or 36'h000000001 if seed == 0; misr <= 0; pattern_cnt <= 0; -> APPLY.
- APPLY: each cycle cut_in = lfsr; misr captures cut_out in the same cycle; lfsr advances; pattern_cnt increments; after NUM_PATTERNS cycles -> DONE.
- DONE: hold signature, pattern_cnt and pass; start=0 -> IDLE. start held high keeps DONE and never auto-restarts.
- abort=1 in any state -> IDLE next cycle; misr/lfsr/pattern_cnt retain their values; done stays 0. abort has priority over start.
- LFSR update: lfsr <= {lfsr[34:0], lfsr[35] ^ lfsr[10]}.
- MISR update: misr <= {misr[14:0], fb} ^ {9'b0, cut_out}, with fb = misr[15]^misr[14]^misr[12]^misr[3].
- cut_in = bist_mode ? lfsr : func_in, combinational. bist_mode = (state == APPLY).
- pattern_cnt saturates at NUM_PATTERNS; it cannot wrap because the exit occurs at equality.

## Timing
- Reset: state=IDLE, lfsr=36'h1, misr=0, pattern_cnt=0, done=0, busy=0, bist_mode=0, pass=0; signature=0 and cut_in=func_in.
- start seen high at edge k -> SEED during cycle k+1 -> APPLY during cycles k+2..k+1+NUM_PATTERNS -> done=1 from cycle k+2+NUM_PATTERNS.
- Total latency from start to done: NUM_PATTERNS+2 cycles.
- The CUT path is combinational, so cut_out must settle within one clock of cut_in.
- Asserting rst_n low mid-run returns all outputs to their reset values immediately (asynchronously).

## Configuration
- LBIST_GOLDEN_CMP_EN defined: a registered comparator drives pass = (misr == golden), updated on entry to DONE and held there.
- LBIST_GOLDEN_CMP_EN undefined: no comparator; pass is tied to 0 and golden is ignored. Software compares the signature externally.

## Structure
- Package lbist_pkg holds:
  - the state enum (IDLE/SEED/APPLY/DONE);
  - LFSR_W=36, MISR_W=16 and CUT_OUT_W=7;
  - the LFSR tap indices and the MISR feedback mask 16'hD008;
  - the zero-seed substitute 36'h1.
- One sub-module, lbist_misr, contains the 16-bit MISR register with its clear and enable inputs. The LFSR, FSM and mux stay in the top level.

## Test plan
- Reset check: assert rst_n=0 mid-APPLY -> done=0, busy=0, signature=0, and cut_in follows func_in=36'hABCDE1234 immediately.
- NUM_PATTERNS=4, seed=0, cut_out tied to 0 -> cut_in sequence 36'h1, 36'h2, 36'h4, 36'h8; signature=16'h0000; pattern_cnt=4; done asserted 6 cycles after start.
- NUM_PATTERNS=2, cut_out tied to 7'h01 -> signature=16'h0003 (16'h0001 after the first pattern).
- Abort on the third APPLY cycle -> next cycle state is IDLE, bist_mode=0, done never asserts; a fresh start then runs a full NUM_PATTERNS cycles.
- start held high through DONE -> done stays 1 with no restart; start=0 -> IDLE the next cycle with done=0.
- With LBIST_GOLDEN_CMP_EN defined, golden=16'h0003 and the NUM_PATTERNS=2 / cut_out=7'h01 run -> pass=1. With golden=16'h0004 -> pass=0. With the macro undefined -> pass=0 in both cases.

Source files
------------

// File: rtl/lbist_pkg.sv
// Shared types and constants for the c432 logic-BIST controller.
package lbist_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEED  = 2'd1,
    APPLY = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int LFSR_W    = 36;
  localparam int MISR_W    = 16;
  localparam int CUT_OUT_W = 7;

  localparam int LFSR_TAP_HI = 35;
  localparam int LFSR_TAP_LO = 10;
  localparam logic [MISR_W-1:0] MISR_POLY = 16'hD008;
  localparam logic [LFSR_W-1:0] LFSR_ZERO_SUB = 36'h000000001;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
    return {v[LFSR_W-2:0], v[LFSR_TAP_HI] ^ v[LFSR_TAP_LO]};
  endfunction

endpackage

// File: rtl/lbist_misr.sv
// 16-bit MISR compacting CUT responses; o_next exposes the value about to be captured.
module lbist_misr
  import lbist_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_clr,
  input  logic                 i_en,
  input  logic [CUT_OUT_W-1:0] i_data,
  output logic [MISR_W-1:0]    o_sig,
  output logic [MISR_W-1:0]    o_next
);

  logic [MISR_W-1:0] r_misr;
  logic              w_fb;

  assign w_fb   = ^(r_misr & MISR_POLY);
  assign o_next = {r_misr[MISR_W-2:0], w_fb} ^ {{(MISR_W-CUT_OUT_W){1'b0}}, i_data};
  assign o_sig  = r_misr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_misr <= '0;
    else if (i_clr) r_misr <= '0;
    else if (i_en)  r_misr <= o_next;
  end

endmodule

// File: rtl/lbist_controller.sv
// Logic-BIST sequencer: LFSR patterns onto the c432 inputs, MISR signature out.
// Define LBIST_GOLDEN_CMP_EN to build the registered golden-signature comparator.
module lbist_controller
  import lbist_pkg::*;
#(
  parameter int NUM_PATTERNS = 1000,
  parameter int CNT_W        = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [LFSR_W-1:0]    seed,
  input  logic [LFSR_W-1:0]    func_in,
  input  logic [CUT_OUT_W-1:0] cut_out,
  input  logic [MISR_W-1:0]    golden,
  output logic [LFSR_W-1:0]    cut_in,
  output logic                 bist_mode,
  output logic                 busy,
  output logic                 done,
  output logic [MISR_W-1:0]    signature,
  output logic                 pass,
  output logic [CNT_W-1:0]     pattern_cnt
);

  state_e            r_state;
  logic [LFSR_W-1:0] r_lfsr;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_apply;
  logic              w_last;
  logic              w_clr;
  logic [MISR_W-1:0] w_misr_next;

  // abort freezes the datapath in the cycle it arrives
  assign w_apply = (r_state == APPLY) && !abort;
  assign w_clr   = (r_state == SEED) && !abort;
  assign w_last  = (r_cnt == CNT_W'(NUM_PATTERNS - 1));

  lbist_misr u_misr (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_clr),
    .i_en   (w_apply),
    .i_data (cut_out),
    .o_sig  (signature),
    .o_next (w_misr_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_lfsr  <= LFSR_ZERO_SUB;
      r_cnt   <= '0;
    end else if (abort) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE:  if (start) r_state <= SEED;
        SEED: begin
          r_lfsr  <= (seed == '0) ? LFSR_ZERO_SUB : seed;
          r_cnt   <= '0;
          r_state <= APPLY;
        end
        APPLY: begin
          r_lfsr <= lfsr_step(r_lfsr);
          r_cnt  <= r_cnt + 1'b1;
          if (w_last) r_state <= DONE;
        end
        DONE:  if (!start) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bist_mode   = (r_state == APPLY);
  assign busy        = (r_state == SEED) || (r_state == APPLY);
  assign done        = (r_state == DONE);
  assign pattern_cnt = r_cnt;
  assign cut_in      = bist_mode ? r_lfsr : func_in;

`ifdef LBIST_GOLDEN_CMP_EN
  logic r_pass;

  // compare against the value the MISR captures on the DONE-entry edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            r_pass <= 1'b0;
    else if (abort)                        r_pass <= 1'b0;
    else if (w_apply && w_last)            r_pass <= (w_misr_next == golden);
    else if (r_state != DONE || !start)    r_pass <= 1'b0;
  end

  assign pass = r_pass;
`else
  logic w_unused_golden;
  assign w_unused_golden = ^{golden, w_misr_next};
  assign pass = 1'b0;
`endif

endmodule
